// File: rtl/vga_pkg.sv
// vga_pkg: lock FSM states, default 640x480 timing shared with the generator, and counter width helper
package vga_pkg;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;
    localparam int H_TOTAL  = 800;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/vga_sync_decoder_edge.sv
// sync_edge_detect: S1 capture of one timing input, normalised to active-high, with leading/trailing pulses
module sync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic sig_i,
    output logic level_o,
    output logic lead_o,
    output logic trail_o
);
    logic s1_q, prev_q, prev_lvl;
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) begin
            s1_q   <= ACTIVE_LOW;
            prev_q <= ACTIVE_LOW;
        end else begin
            s1_q   <= sig_i;
            prev_q <= s1_q;
        end
    assign level_o  = s1_q ^ ACTIVE_LOW;
    assign prev_lvl = prev_q ^ ACTIVE_LOW;
    assign lead_o   = level_o & ~prev_lvl;
    assign trail_o  = ~level_o & prev_lvl;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel coordinates from hsync/vsync/video_en and verifies geometry for lock
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int TOTAL_COLUMNS   = H_TOTAL,
    parameter int TOTAL_ROWS      = V_TOTAL,
    parameter int ACTIVE_COLUMNS  = H_ACTIVE,
    parameter int ACTIVE_ROWS     = V_ACTIVE,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                                         clk_i,
    input  logic                                         reset_ni,
    input  logic                                         hsync_i,
    input  logic                                         vsync_i,
    input  logic                                         video_en_i,
    output logic [cnt_w(ACTIVE_COLUMNS)-1:0]             x_o,
    output logic [cnt_w(ACTIVE_ROWS)-1:0]                y_o,
    output logic [cnt_w(ACTIVE_COLUMNS*ACTIVE_ROWS)-1:0] pixel_o,
    output logic                                         pixel_valid_o,
    output logic                                         frame_start_o,
    output logic                                         locked_o,
    output logic                                         error_o,
    output logic [cnt_w(TOTAL_COLUMNS)-1:0]              line_len_o
);
    localparam int XW = cnt_w(ACTIVE_COLUMNS);
    localparam int YW = cnt_w(ACTIVE_ROWS);
    localparam int PW = cnt_w(ACTIVE_COLUMNS * ACTIVE_ROWS);
    localparam int HW = cnt_w(TOTAL_COLUMNS);
    localparam int VW = cnt_w(TOTAL_ROWS);

    logic hs_lead, vs_lead, ve, ve_lead, ve_trail;
    logic unused_hs_lvl, unused_hs_trail, unused_vs_lvl, unused_vs_trail;
    state_e state_q, state_d;
    logic first_q, first_d, valid_q, valid_d, fs_q, err_q, err_d;
    logic line_fail, frame_fail;
    logic [HW-1:0] h_cnt_q, h_cnt_d, h_inc, line_len_q, line_len_d;
    logic [XW-1:0] a_cnt_q, a_cnt_d, x_q, x_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d, v_eff;
    logic [YW-1:0] y_q, y_d, y_eff;
    logic [PW-1:0] pcnt_q, pcnt_d, pix_q, pix_d;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs (
        .clk_i(clk_i), .reset_ni(reset_ni), .sig_i(hsync_i),
        .level_o(unused_hs_lvl), .lead_o(hs_lead), .trail_o(unused_hs_trail)
    );
    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs (
        .clk_i(clk_i), .reset_ni(reset_ni), .sig_i(vsync_i),
        .level_o(unused_vs_lvl), .lead_o(vs_lead), .trail_o(unused_vs_trail)
    );
    sync_edge_detect #(.ACTIVE_LOW(1'b0)) u_ve (
        .clk_i(clk_i), .reset_ni(reset_ni), .sig_i(video_en_i),
        .level_o(ve), .lead_o(ve_lead), .trail_o(ve_trail)
    );

    // Every counter saturates so a lost sync can never wrap back onto a matching value.
    // v_eff/y_eff include a same-cycle hsync/video-end so the frame check sees them before the vsync clear.
    always_comb begin
        h_inc      = (&h_cnt_q) ? h_cnt_q : h_cnt_q + 1'b1;
        h_cnt_d    = hs_lead ? '0 : h_inc;
        line_len_d = hs_lead ? h_inc : line_len_q;
        a_cnt_d    = hs_lead ? XW'(ve) : ((&a_cnt_q) ? a_cnt_q : a_cnt_q + XW'(ve));
        v_eff      = (hs_lead && !(&v_cnt_q)) ? v_cnt_q + 1'b1 : v_cnt_q;
        v_cnt_d    = vs_lead ? '0 : v_eff;
        y_eff      = (ve_trail && !(&y_q)) ? y_q + 1'b1 : y_q;
        y_d        = vs_lead ? '0 : y_eff;
        x_d        = ve_lead ? '0 : ((ve && !(&x_q)) ? x_q + 1'b1 : x_q);
        pcnt_d     = vs_lead ? '0 : ((ve && !(&pcnt_q)) ? pcnt_q + 1'b1 : pcnt_q);
        pix_d      = vs_lead ? '0 : (ve ? pcnt_q : pix_q);
        first_d    = first_q && !hs_lead;
        line_fail  = hs_lead && !first_q && (h_inc != HW'(TOTAL_COLUMNS) ||
                     (a_cnt_q != '0 && a_cnt_q != XW'(ACTIVE_COLUMNS)));
        frame_fail = v_eff != VW'(TOTAL_ROWS) || y_eff != YW'(ACTIVE_ROWS);
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH:  if (vs_lead) state_d = ACQUIRE;
            ACQUIRE: if (line_fail) begin
                         state_d = SEARCH;
                         err_d   = 1'b1;
                     end else if (vs_lead) begin
                         state_d = frame_fail ? ACQUIRE : LOCKED;
                         err_d   = frame_fail;
                     end
            LOCKED:  if (line_fail || (vs_lead && frame_fail)) begin
                         state_d = SEARCH;
                         err_d   = 1'b1;
                     end
            default: state_d = SEARCH;
        endcase
        valid_d = (state_d == LOCKED) && ve;
    end

    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) begin
            state_q    <= SEARCH;
            first_q    <= 1'b1;
            h_cnt_q    <= '0;
            line_len_q <= '0;
            a_cnt_q    <= '0;
            v_cnt_q    <= '0;
            y_q        <= '0;
            x_q        <= '0;
            pcnt_q     <= '0;
            pix_q      <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            h_cnt_q    <= h_cnt_d;
            line_len_q <= line_len_d;
            a_cnt_q    <= a_cnt_d;
            v_cnt_q    <= v_cnt_d;
            y_q        <= y_d;
            x_q        <= x_d;
            pcnt_q     <= pcnt_d;
            pix_q      <= pix_d;
            valid_q    <= valid_d;
            fs_q       <= vs_lead;
            err_q      <= err_d;
        end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign pixel_o       = pix_q;
    assign pixel_valid_o = valid_q;
    assign frame_start_o = fs_q;
    assign locked_o      = state_q == LOCKED;
    assign error_o       = err_q;
    assign line_len_o    = line_len_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench on a scaled-down geometry, active-low and active-high sync instances
module tb_vga_sync_decoder;
    localparam int TC = 20, AC = 12, TR = 10, AR = 6;
    localparam int HS0 = 14, HS1 = 17, VS0 = 7, VS1 = 9;
    localparam int XW = $clog2(AC) + 1, YW = $clog2(AR) + 1;
    localparam int PW = $clog2(AC * AR) + 1, HW = $clog2(TC) + 1;

    logic clk_i = 1'b0;
    logic reset_ni;
    logic hsync, vsync, video_en, hsync_h, vsync_h;
    logic [XW-1:0] x_o, unused_x_h;
    logic [YW-1:0] y_o, unused_y_h;
    logic [PW-1:0] pixel_o, unused_p_h;
    logic [HW-1:0] line_len_o, unused_ll_h;
    logic pixel_valid_o, frame_start_o, locked_o, error_o;
    logic unused_v_h, unused_fs_h, locked_h, error_h;

    int col = 0, row = 0, fr = 0, line_len = TC, frame_rows = TR;
    int p1 = -1, p2 = -1;
    int err_cnt = 0, err_h_cnt = 0, checks = 0, passed = 0;

    always #5 clk_i = ~clk_i;
    assign hsync_h = ~hsync;
    assign vsync_h = ~vsync;

    vga_sync_decoder #(.TOTAL_COLUMNS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLUMNS(AC),
                       .ACTIVE_ROWS(AR), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .hsync_i(hsync), .vsync_i(vsync),
        .video_en_i(video_en), .x_o(x_o), .y_o(y_o), .pixel_o(pixel_o),
        .pixel_valid_o(pixel_valid_o), .frame_start_o(frame_start_o),
        .locked_o(locked_o), .error_o(error_o), .line_len_o(line_len_o)
    );

    vga_sync_decoder #(.TOTAL_COLUMNS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLUMNS(AC),
                       .ACTIVE_ROWS(AR), .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
        .clk_i(clk_i), .reset_ni(reset_ni), .hsync_i(hsync_h), .vsync_i(vsync_h),
        .video_en_i(video_en), .x_o(unused_x_h), .y_o(unused_y_h), .pixel_o(unused_p_h),
        .pixel_valid_o(unused_v_h), .frame_start_o(unused_fs_h),
        .locked_o(locked_h), .error_o(error_h), .line_len_o(unused_ll_h)
    );

    function automatic int key(input int f, input int r, input int c);
        return f * 1000000 + r * 1000 + c;
    endfunction

    task automatic drive();
        hsync    = !(col >= HS0 && col < HS1);
        vsync    = !(row >= VS0 && row < VS1);
        video_en = (col < AC) && (row < AR);
    endtask

    // Outputs seen after a step belong to the position driven two steps earlier (p2).
    task automatic step();
        @(negedge clk_i);
        if (error_o === 1'b1) err_cnt++;
        if (error_h === 1'b1) err_h_cnt++;
        p2 = p1;
        p1 = key(fr, row, col);
        col++;
        if (col == line_len) begin
            col = 0;
            line_len = TC;
            row++;
            if (row == frame_rows) begin
                row = 0;
                frame_rows = TR;
                fr++;
            end
        end
        drive();
    endtask

    task automatic run_to(input int f, input int r, input int c);
        int n = 0;
        while (p2 != key(f, r, c) && n < 4000) begin
            step();
            n++;
        end
        if (p2 != key(f, r, c)) begin
            checks++;
            $display("FAIL run_to: position %0d not reached, at %0d", key(f, r, c), p2);
        end
    endtask

    task automatic model_to(input int f, input int r, input int c);
        int n = 0;
        while (key(fr, row, col) != key(f, r, c) && n < 4000) begin
            step();
            n++;
        end
        if (key(fr, row, col) != key(f, r, c)) begin
            checks++;
            $display("FAIL model_to: position %0d not reached", key(f, r, c));
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        drive();
        repeat (3) @(negedge clk_i);
        checks++; if (locked_o !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked_o); else passed++;
        checks++; if ({pixel_valid_o, frame_start_o, error_o} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {pixel_valid_o, frame_start_o, error_o}); else passed++;
        checks++; if (line_len_o !== '0) $display("FAIL rst_line_len: got %0d want 0", line_len_o); else passed++;
        checks++; if ({x_o, y_o, pixel_o} !== '0) $display("FAIL rst_xyp: got %0d/%0d/%0d want 0/0/0", x_o, y_o, pixel_o); else passed++;
        reset_ni = 1'b1;
    endtask

    task automatic test_lock();
        run_to(0, VS0, 0);
        checks++; if (frame_start_o !== 1'b1) $display("FAIL fs_first: got %b want 1", frame_start_o); else passed++;
        checks++; if (locked_o !== 1'b0) $display("FAIL acq_unlocked: got %b want 0", locked_o); else passed++;
        run_to(1, VS0 - 1, TC - 1);
        checks++; if (locked_o !== 1'b0) $display("FAIL pre_lock: got %b want 0", locked_o); else passed++;
        step();
        checks++; if (locked_o !== 1'b1) $display("FAIL lock_vs2: got %b want 1", locked_o); else passed++;
        checks++; if (locked_h !== 1'b1) $display("FAIL lock_active_high: got %b want 1", locked_h); else passed++;
        checks++; if (line_len_o !== HW'(TC)) $display("FAIL line_len: got %0d want %0d", line_len_o, TC); else passed++;
        run_to(2, 0, 0);
        checks++; if ({pixel_valid_o, x_o, y_o, pixel_o} !== {1'b1, XW'(0), YW'(0), PW'(0)})
            $display("FAIL first_pixel: got v%b x%0d y%0d p%0d want v1 x0 y0 p0", pixel_valid_o, x_o, y_o, pixel_o); else passed++;
        run_to(2, AR - 1, AC - 1);
        checks++; if ({pixel_valid_o, x_o, y_o, pixel_o} !== {1'b1, XW'(AC - 1), YW'(AR - 1), PW'(AC * AR - 1)})
            $display("FAIL last_pixel: got v%b x%0d y%0d p%0d want v1 x%0d y%0d p%0d", pixel_valid_o, x_o, y_o, pixel_o, AC - 1, AR - 1, AC * AR - 1); else passed++;
        step();
        checks++; if (pixel_valid_o !== 1'b0) $display("FAIL valid_falls: got %b want 0", pixel_valid_o); else passed++;
        run_to(3, 0, 0);
        checks++; if (err_cnt + err_h_cnt !== 0) $display("FAIL clean_frames_err: got %0d pulses want 0", err_cnt + err_h_cnt); else passed++;
        checks++; if (locked_o !== 1'b1) $display("FAIL still_locked: got %b want 1", locked_o); else passed++;
    endtask

    task automatic test_stretch();
        int e0;
        model_to(3, 2, 0);
        line_len = TC + 1;
        e0 = err_cnt;
        run_to(3, 3, HS0 - 1);
        checks++; if ({locked_o, error_o} !== 2'b10) $display("FAIL stretch_pre: got %b want 10", {locked_o, error_o}); else passed++;
        step();
        checks++; if ({locked_o, error_o} !== 2'b01) $display("FAIL stretch_err: got lock/err %b want 01", {locked_o, error_o}); else passed++;
        checks++; if (line_len_o !== HW'(TC + 1)) $display("FAIL stretch_len: got %0d want %0d", line_len_o, TC + 1); else passed++;
        run_to(4, VS0, 0);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL stretch_once: got %0d pulses want 1", err_cnt - e0); else passed++;
        checks++; if (locked_o !== 1'b1) $display("FAIL stretch_relock: got %b want 1", locked_o); else passed++;
    endtask

    task automatic test_short_frame();
        model_to(5, 0, 1);
        frame_rows = TR - 1;
        run_to(6, VS0 - 1, TC - 1);
        checks++; if ({locked_o, error_o} !== 2'b10) $display("FAIL short_pre: got %b want 10", {locked_o, error_o}); else passed++;
        step();
        checks++; if ({locked_o, error_o, frame_start_o} !== 3'b011) $display("FAIL short_err: got lock/err/fs %b want 011", {locked_o, error_o, frame_start_o}); else passed++;
        run_to(7, VS0, 0);
        checks++; if (locked_o !== 1'b0) $display("FAIL short_search: got %b want 0", locked_o); else passed++;
        run_to(8, VS0, 0);
        checks++; if (locked_o !== 1'b1) $display("FAIL short_relock: got %b want 1", locked_o); else passed++;
    endtask

    task automatic test_saturation();
        model_to(8, VS0 + 1, 0);
        line_len = (1 << HW) + TC;
        run_to(8, VS0 + 2, HS0 - 1);
        checks++; if (locked_o !== 1'b1) $display("FAIL sat_pre: got %b want 1", locked_o); else passed++;
        step();
        checks++; if ({locked_o, error_o} !== 2'b01) $display("FAIL sat_err: got lock/err %b want 01", {locked_o, error_o}); else passed++;
        checks++; if (line_len_o !== HW'((1 << HW) - 1)) $display("FAIL sat_len: got %0d want %0d", line_len_o, (1 << HW) - 1); else passed++;
    endtask

    task automatic test_reset_mid();
        run_to(10, VS0, 0);
        checks++; if (locked_o !== 1'b1) $display("FAIL mid_pre_lock: got %b want 1", locked_o); else passed++;
        model_to(11, 2, 5);
        checks++; if ({pixel_valid_o, x_o} !== {1'b1, XW'(3)}) $display("FAIL mid_pre_pixel: got v%b x%0d want v1 x3", pixel_valid_o, x_o); else passed++;
        #2 reset_ni = 1'b0;
        #1;
        checks++; if ({locked_o, pixel_valid_o, frame_start_o, error_o} !== 4'b0000) $display("FAIL mid_flags: got %b want 0000", {locked_o, pixel_valid_o, frame_start_o, error_o}); else passed++;
        checks++; if ({x_o, y_o, pixel_o, line_len_o} !== '0) $display("FAIL mid_counters: got x%0d y%0d p%0d len%0d want 0", x_o, y_o, pixel_o, line_len_o); else passed++;
        @(negedge clk_i);
        reset_ni = 1'b1;
        run_to(11, VS0, 0);
        checks++; if (locked_o !== 1'b0) $display("FAIL mid_acquire: got %b want 0", locked_o); else passed++;
        run_to(12, VS0 - 1, TC - 1);
        checks++; if (locked_o !== 1'b0) $display("FAIL mid_not_yet: got %b want 0", locked_o); else passed++;
        step();
        checks++; if (locked_o !== 1'b1) $display("FAIL mid_relock: got %b want 1", locked_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_short_frame();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA sync pulse generator. It samples hsync/vsync/video_en from a timing source and rebuilds the pixel coordinates and linear pixel index from those pulses. It also checks that line and frame geometry match the parameters and reports lock. Downstream consumers (frame-buffer writer, capture/compare logic) use it to address pixels from sync signals alone.

## Interface
Parameters:
- TOTAL_COLUMNS, 800, clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLUMNS, 640, video_en clocks per active line
- ACTIVE_ROWS, 480, active lines per frame
- SYNC_ACTIVE_LOW, 1, 1: hsync/vsync asserted low; 0: asserted high

Ports:
- clk_i  in  1  pixel clock; the block's single clock
- reset_ni  in  1  asynchronous, active-low reset
- hsync_i  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync_i  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_en_i  in  1  active-video qualifier, active high
- x_o  out  $clog2(ACTIVE_COLUMNS)+1  column of current pixel
- y_o  out  $clog2(ACTIVE_ROWS)+1  row of current pixel
- pixel_o  out  $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)+1  linear index y*ACTIVE_COLUMNS+x
- pixel_valid_o  out  1  x_o/y_o/pixel_o are a valid locked pixel
- frame_start_o  out  1  one-cycle pulse on the vsync leading edge
- locked_o  out  1  geometry verified; stays high while it keeps matching
- error_o  out  1  one-cycle pulse on any geometry mismatch
- line_len_o  out  $clog2(TOTAL_COLUMNS)+1  last measured line length in clocks

## Operation
**Input and edges**
- hsync_i, vsync_i and video_en_i are registered once (stage S1), then normalised to active-high.
- A leading edge is the inactive→asserted transition between S1 and the previous S1 value.

**Counters (reset on any hsync leading edge)**
- h_cnt counts clocks since the last hsync leading edge.
- At the edge, line_len_o ← h_cnt+1, then h_cnt ← 0. The first line after reset is not checked.
- a_cnt counts S1 video_en-high clocks in the line.
- x counts active pixels: it is 0 on the first video_en clock and increments while video_en is high.
- At a video_en falling edge: y increments and an active-line counter increments.
- line counter v_cnt increments on each hsync leading edge.
- pixel index: +1 per video_en clock; reset to 0 at the vsync leading edge. No multiplier is used.

**vsync leading edge**
- y, v_cnt, the active-line counter and the pixel index all clear.
- frame_start_o pulses.
- If an hsync leading edge occurs in the same cycle, hsync processing happens first, then the vsync clears win.

**Line check (at every hsync leading edge, except the first line after reset)**
- Fail if line_len ≠ TOTAL_COLUMNS.
- Fail if a_cnt ∉ {0, ACTIVE_COLUMNS}.

**Frame check (at the vsync leading edge)**
- Fail if v_cnt ≠ TOTAL_ROWS.
- Fail if the active-line count ≠ ACTIVE_ROWS.

**FSM states: SEARCH, ACQUIRE, LOCKED**
- SEARCH: a vsync leading edge moves to ACQUIRE.
- ACQUIRE: a line-check failure returns to SEARCH and pulses error_o. At the next vsync leading edge, a passing frame check moves to LOCKED; a failing one stays in ACQUIRE and pulses error_o.
- LOCKED: any line-check or frame-check failure moves to SEARCH and pulses error_o.
- locked_o = (state == LOCKED).

**Outputs**
- pixel_valid_o = LOCKED & S1 video_en.
- When pixel_valid_o is low, x_o/y_o/pixel_o still carry the counters and are don't-care.

**Overflow**
- Counters saturate at their maximum, so a missing sync cannot wrap into a false match. A saturated count always fails its check.

## Timing
- Reset (asynchronous assert, synchronous-style release) returns the block to SEARCH:
  - Zero: all counters, x_o, y_o, pixel_o, line_len_o, pixel_valid_o, frame_start_o, locked_o, error_o.
  - Previous-S1 registers are set to the inactive level, so no edge is produced on the first sample.
- Latency is 2 clocks from an input change to the corresponding output: S1, then the output register.
- x_o/y_o/pixel_o are registered and aligned with pixel_valid_o.
- frame_start_o, error_o and the locked_o transition appear 2 clocks after the causing input edge.
- Lock needs at least one full verified frame after the first vsync leading edge.
- locked_o deasserts in the same cycle error_o pulses. In LOCKED, pixel_valid_o is low from that cycle on.
- Reset asserted mid-frame: outputs clear immediately; after release, the first vsync leading edge starts a new acquisition.

## Structure
- Package vga_pkg holds:
  - the state enum for SEARCH/ACQUIRE/LOCKED;
  - default 640x480 timing constants shared with the generator;
  - a localparam width helper for the x/y/pixel widths.
- One sub-module, sync_edge_detect: S1 register, polarity normalisation, leading/trailing-edge pulses. It is instantiated for hsync, vsync and video_en.

## Test plan
- Stimulus: the sync pulse generator at default parameters drives the inputs for 3 frames after reset release. Required:
  - locked_o high starting 2 clocks after the second vsync leading edge;
  - line_len_o = 800;
  - no error_o.
- Locked, first active pixel: pixel_valid_o with x_o=0, y_o=0, pixel_o=0. Last pixel: x_o=639, y_o=479, pixel_o=307199, after which pixel_valid_o falls.
- One line stretched to 801 clocks while locked: error_o pulses once, locked_o falls in the same cycle, and lock is re-acquired after one clean frame.
- Frame with 524 lines: error_o pulses at the vsync leading edge and state goes to SEARCH. SYNC_ACTIVE_LOW=0 with an inverted-polarity source also locks.
- Hold hsync inactive for more than 2048 clocks: h_cnt saturates, and the next hsync edge gives error_o with no wrap-induced pass.
- reset_ni asserted mid-line while locked: all outputs read 0 asynchronously, and after release locked_o stays low until a full frame is verified.
